// File: rtl/jtag_ir_dr_chain_if.sv
// Interface between the TAP-side driver / core logic and the IR/DR chain.
// master: TAP controller plus core (drives TDI, tap_state, user_cap_data).
// slave:  the IR/DR chain itself.
interface jtag_ir_dr_chain_if #(
    parameter int unsigned IR_WIDTH = 4,
    parameter int unsigned DR_WIDTH = 32
);
    logic                TDI;
    logic [3:0]          tap_state;
    logic                TDO;
    logic                TDO_EN;
    logic [IR_WIDTH-1:0] ir_out;
    logic                user_sel;
    logic [DR_WIDTH-1:0] user_cap_data;
    logic [DR_WIDTH-1:0] user_upd_data;
    logic                user_upd_stb;

    modport master (
        output TDI, tap_state, user_cap_data,
        input  TDO, TDO_EN, ir_out, user_sel, user_upd_data, user_upd_stb
    );

    modport slave (
        input  TDI, tap_state, user_cap_data,
        output TDO, TDO_EN, ir_out, user_sel, user_upd_data, user_upd_stb
    );
endinterface

// File: rtl/jtag_ir_dr_chain.sv
// JTAG instruction / data register chain sitting behind the TAP state machine.
// Implements IR, BYPASS, optional IDCODE and one USER data register plus the TDO mux.
// Optional feature macro: JTAG_IDCODE_EN (IDCODE register present, reset opcode IDCODE).
module jtag_ir_dr_chain #(
    parameter int unsigned         IR_WIDTH   = 4,
    parameter int unsigned         DR_WIDTH   = 32,
    parameter logic [31:0]         IDCODE_VAL = 32'h1234_5ABD,
    parameter logic [IR_WIDTH-1:0] OPC_IDCODE = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0] OPC_USER   = IR_WIDTH'(2),
    parameter logic [IR_WIDTH-1:0] OPC_BYPASS = '1
) (
    input  logic                 TCK,
    input  logic                 TRST,
    jtag_ir_dr_chain_if.slave    jtag
);

    typedef enum logic [3:0] {
        StTlr   = 4'h0, StRti   = 4'h1, StSelDr = 4'h2, StCapDr = 4'h3,
        StShDr  = 4'h4, StEx1Dr = 4'h5, StPDr   = 4'h6, StEx2Dr = 4'h7,
        StUpDr  = 4'h8, StSelIr = 4'h9, StCapIr = 4'hA, StShIr  = 4'hB,
        StEx1Ir = 4'hC, StPIr   = 4'hD, StEx2Ir = 4'hE, StUpIr  = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {SelBypass, SelIdcode, SelUser} dr_sel_e;

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IrReset = OPC_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IrReset = OPC_BYPASS;
`endif
    // Fixed IR capture pattern: ...0001, lets a host find the IR length.
    localparam logic [IR_WIDTH-1:0] IrCapture = IR_WIDTH'(1);

    tap_state_e          state;
    dr_sel_e             dr_sel;
    logic                sel_lsb;

    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
    logic                bypass_q, bypass_d;
    logic [DR_WIDTH-1:0] user_shift_q, user_shift_d;
    logic [DR_WIDTH-1:0] user_upd_data_q, user_upd_data_d;
    logic                user_upd_stb_q, user_upd_stb_d;
`ifdef JTAG_IDCODE_EN
    logic [31:0]         id_shift_q, id_shift_d;
`else
    // IDCODE parameters are intentionally unused when the register is absent.
    logic                unused_idcode;
    assign unused_idcode = ^{IDCODE_VAL, OPC_IDCODE};
`endif

    assign state = tap_state_e'(jtag.tap_state);

    // Instruction decode; anything unrecognised selects BYPASS.
    always_comb begin
        dr_sel = SelBypass;
        if (ir_out_q == OPC_USER) begin
            dr_sel = SelUser;
        end
`ifdef JTAG_IDCODE_EN
        else if (ir_out_q == OPC_IDCODE) begin
            dr_sel = SelIdcode;
        end
`endif
    end

    // LSB of the currently selected data register.
    always_comb begin
        sel_lsb = bypass_q;
        case (dr_sel)
            SelUser:   sel_lsb = user_shift_q[0];
`ifdef JTAG_IDCODE_EN
            SelIdcode: sel_lsb = id_shift_q[0];
`endif
            default:   sel_lsb = bypass_q;
        endcase
    end

    // Next-state for all registers, keyed on the TAP state being left.
    always_comb begin
        ir_shift_d      = ir_shift_q;
        ir_out_d        = ir_out_q;
        bypass_d        = bypass_q;
        user_shift_d    = user_shift_q;
        user_upd_data_d = user_upd_data_q;
        user_upd_stb_d  = 1'b0;
`ifdef JTAG_IDCODE_EN
        id_shift_d      = id_shift_q;
`endif
        case (state)
            StTlr:   ir_out_d   = IrReset;
            StCapIr: ir_shift_d = IrCapture;
            StShIr:  ir_shift_d = {jtag.TDI, ir_shift_q[IR_WIDTH-1:1]};
            StUpIr:  ir_out_d   = ir_shift_q;
            StCapDr: begin
                case (dr_sel)
                    SelUser:   user_shift_d = jtag.user_cap_data;
`ifdef JTAG_IDCODE_EN
                    SelIdcode: id_shift_d   = IDCODE_VAL;
`endif
                    default:   bypass_d     = 1'b0;
                endcase
            end
            StShDr: begin
                case (dr_sel)
                    // Concat-and-shift form also works when DR_WIDTH is 1.
                    SelUser:   user_shift_d = DR_WIDTH'({jtag.TDI, user_shift_q} >> 1);
`ifdef JTAG_IDCODE_EN
                    SelIdcode: id_shift_d   = {jtag.TDI, id_shift_q[31:1]};
`endif
                    default:   bypass_d     = jtag.TDI;
                endcase
            end
            StUpDr: begin
                if (dr_sel == SelUser) begin
                    user_upd_data_d = user_shift_q;
                    user_upd_stb_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State registers; TRST clears everything immediately.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_shift_q      <= '0;
            ir_out_q        <= IrReset;
            bypass_q        <= 1'b0;
            user_shift_q    <= '0;
            user_upd_data_q <= '0;
            user_upd_stb_q  <= 1'b0;
`ifdef JTAG_IDCODE_EN
            id_shift_q      <= '0;
`endif
        end else begin
            ir_shift_q      <= ir_shift_d;
            ir_out_q        <= ir_out_d;
            bypass_q        <= bypass_d;
            user_shift_q    <= user_shift_d;
            user_upd_data_q <= user_upd_data_d;
            user_upd_stb_q  <= user_upd_stb_d;
`ifdef JTAG_IDCODE_EN
            id_shift_q      <= id_shift_d;
`endif
        end
    end

    // Output mux: TDO driven only in the two shift states.
    always_comb begin
        jtag.TDO    = 1'b0;
        jtag.TDO_EN = 1'b0;
        if (state == StShIr) begin
            jtag.TDO    = ir_shift_q[0];
            jtag.TDO_EN = 1'b1;
        end else if (state == StShDr) begin
            jtag.TDO    = sel_lsb;
            jtag.TDO_EN = 1'b1;
        end
    end

    assign jtag.ir_out        = ir_out_q;
    assign jtag.user_sel      = (ir_out_q == OPC_USER);
    assign jtag.user_upd_data = user_upd_data_q;
    assign jtag.user_upd_stb  = user_upd_stb_q;

endmodule

// File: tb/tb_jtag_ir_dr_chain.sv
// Self-checking bench for jtag_ir_dr_chain; build with and without JTAG_IDCODE_EN.
module tb_jtag_ir_dr_chain;

    localparam logic [3:0] TLR = 4'h0, RTI = 4'h1, SELDR = 4'h2, CAPDR = 4'h3,
                           SHDR = 4'h4, EX1DR = 4'h5, UPDR = 4'h8, SELIR = 4'h9,
                           CAPIR = 4'hA, SHIR = 4'hB, EX1IR = 4'hC, UPIR = 4'hF;
    localparam logic [3:0]  OPC_IDCODE = 4'b0001;
    localparam logic [3:0]  OPC_USER   = 4'b0010;
    localparam logic [3:0]  OPC_BYPASS = 4'b1111;
    localparam logic [31:0] IDCODE     = 32'h1234_5ABD;
`ifdef JTAG_IDCODE_EN
    localparam logic [3:0]  RESET_OPC  = OPC_IDCODE;
`else
    localparam logic [3:0]  RESET_OPC  = OPC_BYPASS;
`endif

    logic tck = 1'b0;
    logic trst = 1'b0;
    jtag_ir_dr_chain_if jif ();

    jtag_ir_dr_chain dut (
        .TCK  (tck),
        .TRST (trst),
        .jtag (jif)
    );

    always #5 tck = ~tck;

    int n_checks = 0;
    int n_fail = 0;
    int stb_count = 0;
    int en_err = 0;
    logic tdo_s;
    logic [3:0]  model_ir;
    logic [31:0] model_upd;

    // Model: which data register an opcode selects (0 bypass, 1 idcode, 2 user).
    function automatic int dr_kind(input logic [3:0] opc);
        if (opc == OPC_USER) return 2;
`ifdef JTAG_IDCODE_EN
        if (opc == OPC_IDCODE) return 1;
`endif
        return 0;
    endfunction

    // Model: TDO stream of an n-bit DR scan.
    function automatic logic [31:0] exp_dr_tdo(input int kind, input int n,
                                               input logic [31:0] tdi, input logic [31:0] cap);
        logic [63:0] v;
        if (kind == 2) v = {32'b0, cap};
        else if (kind == 1) v = {32'b0, IDCODE};
        else v = {32'b0, tdi} << 1;
        v = v & ((64'd1 << n) - 64'd1);
        return v[31:0];
    endfunction

    // Model: USER register contents after capturing cap and shifting n bits of tdi.
    function automatic logic [31:0] exp_user_final(input int n, input logic [31:0] tdi,
                                                   input logic [31:0] cap);
        logic [63:0] v;
        logic [63:0] t;
        t = {32'b0, tdi} & ((64'd1 << n) - 64'd1);
        v = ({32'b0, cap} >> n) | (t << (32 - n));
        return v[31:0];
    endfunction

    task automatic tick(input logic [3:0] st, input logic tdi);
        @(negedge tck);
        jif.tap_state = st;
        jif.TDI = tdi;
        #1;
        tdo_s = jif.TDO;
        if (jif.TDO_EN !== ((st == SHDR) || (st == SHIR))) en_err++;
        if (jif.user_upd_stb === 1'b1) stb_count++;
        @(posedge tck);
    endtask

    task automatic ir_scan(input logic [3:0] opc, output logic [3:0] tdo_v);
        en_err = 0;
        stb_count = 0;
        tick(SELDR, 1'b0);
        tick(SELIR, 1'b0);
        tick(CAPIR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(SHIR, opc[i]);
            tdo_v[i] = tdo_s;
        end
        tick(EX1IR, 1'b0);
        tick(UPIR, 1'b0);
        tick(RTI, 1'b0);
        #1;
    endtask

    task automatic dr_scan(input int n, input logic [31:0] tdi, output logic [31:0] tdo_v);
        en_err = 0;
        stb_count = 0;
        tdo_v = '0;
        tick(SELDR, 1'b0);
        tick(CAPDR, 1'b0);
        for (int i = 0; i < n; i++) begin
            tick(SHDR, tdi[i]);
            tdo_v[i] = tdo_s;
        end
        tick(EX1DR, 1'b0);
        tick(UPDR, 1'b0);
        tick(RTI, 1'b0);
        tick(RTI, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        trst = 1'b0;
        jif.tap_state = TLR;
        jif.TDI = 1'b0;
        jif.user_cap_data = '0;
        #12;
        n_checks++;
        if (jif.ir_out !== RESET_OPC) begin
            n_fail++; $display("FAIL reset_ir_out: got %h want %h", jif.ir_out, RESET_OPC);
        end
        n_checks++;
        if (jif.user_sel !== 1'b0) begin
            n_fail++; $display("FAIL reset_user_sel: got %b want 0", jif.user_sel);
        end
        n_checks++;
        if (jif.user_upd_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_upd_data: got %h want 0", jif.user_upd_data);
        end
        n_checks++;
        if (jif.user_upd_stb !== 1'b0) begin
            n_fail++; $display("FAIL reset_upd_stb: got %b want 0", jif.user_upd_stb);
        end
        n_checks++;
        if (jif.TDO !== 1'b0 || jif.TDO_EN !== 1'b0) begin
            n_fail++; $display("FAIL reset_tdo: got %b/%b want 0/0", jif.TDO, jif.TDO_EN);
        end
        @(negedge tck);
        trst = 1'b1;
        tick(TLR, 1'b0);
        tick(RTI, 1'b0);
        model_ir = RESET_OPC;
        model_upd = '0;
    endtask

    // First DR scan after reset: IDCODE when enabled, else BYPASS.
    task automatic test_post_reset_dr();
        logic [31:0] tdi, tdo_v, exp;
        tdi = $urandom;
        dr_scan(32, tdi, tdo_v);
        exp = exp_dr_tdo(dr_kind(model_ir), 32, tdi, 32'h0);
        n_checks++;
        if (tdo_v !== exp) begin
            n_fail++; $display("FAIL post_reset_dr_tdo: got %h want %h", tdo_v, exp);
        end
        n_checks++;
        if (en_err != 0 || stb_count != 0) begin
            n_fail++; $display("FAIL post_reset_dr_en_stb: en_err %0d stb %0d want 0 0",
                               en_err, stb_count);
        end
        n_checks++;
        if (jif.ir_out !== RESET_OPC) begin
            n_fail++; $display("FAIL post_reset_ir_out: got %h want %h", jif.ir_out, RESET_OPC);
        end
    endtask

    task automatic test_ir_scan();
        logic [3:0] tdo_v, opc;
        ir_scan(4'b1101, tdo_v);
        model_ir = 4'b1101;
        n_checks++;
        if (tdo_v !== 4'b0001 || en_err != 0) begin
            n_fail++; $display("FAIL ir_capture_tdo: got %b en_err %0d want 0001 0", tdo_v, en_err);
        end
        n_checks++;
        if (jif.ir_out !== 4'b1101 || jif.user_sel !== 1'b0) begin
            n_fail++; $display("FAIL ir_update: got %b sel %b want 1101 0",
                               jif.ir_out, jif.user_sel);
        end
        for (int k = 0; k < 4; k++) begin
            opc = 4'($urandom);
            ir_scan(opc, tdo_v);
            model_ir = opc;
            n_checks++;
            if (tdo_v !== 4'b0001 || jif.ir_out !== opc ||
                jif.user_sel !== (opc == OPC_USER)) begin
                n_fail++; $display("FAIL ir_random: tdo %b ir %h sel %b want 0001 %h %b",
                                   tdo_v, jif.ir_out, jif.user_sel, opc, opc == OPC_USER);
            end
        end
    endtask

    task automatic test_bypass();
        logic [3:0] t4;
        logic [31:0] tdo_v, tdi, exp;
        ir_scan(OPC_BYPASS, t4);
        model_ir = OPC_BYPASS;
        dr_scan(4, 32'b1101, tdo_v);
        n_checks++;
        if (tdo_v[3:0] !== 4'b1010) begin
            n_fail++; $display("FAIL bypass_fixed: got %b want 1010", tdo_v[3:0]);
        end
        tdi = $urandom;
        dr_scan(20, tdi, tdo_v);
        exp = exp_dr_tdo(0, 20, tdi, 32'h0);
        n_checks++;
        if (tdo_v !== exp || stb_count != 0 || en_err != 0) begin
            n_fail++; $display("FAIL bypass_random: got %h stb %0d want %h 0",
                               tdo_v, stb_count, exp);
        end
    endtask

    task automatic test_user_fixed();
        logic [3:0] t4;
        logic [31:0] tdo_v;
        ir_scan(OPC_USER, t4);
        model_ir = OPC_USER;
        n_checks++;
        if (jif.user_sel !== 1'b1) begin
            n_fail++; $display("FAIL user_sel: got %b want 1", jif.user_sel);
        end
        jif.user_cap_data = 32'hDEAD_BEEF;
        dr_scan(32, 32'h0000_00A5, tdo_v);
        n_checks++;
        if (tdo_v !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL user_fixed_tdo: got %h want deadbeef", tdo_v);
        end
        n_checks++;
        if (jif.user_upd_data !== 32'h0000_00A5 || stb_count != 1) begin
            n_fail++; $display("FAIL user_fixed_upd: got %h stb %0d want 000000a5 1",
                               jif.user_upd_data, stb_count);
        end
        model_upd = 32'h0000_00A5;
        // Capture -> Exit1 -> Update without shifting writes the capture back.
        jif.user_cap_data = $urandom;
        dr_scan(0, 32'h0, tdo_v);
        n_checks++;
        if (jif.user_upd_data !== jif.user_cap_data || stb_count != 1) begin
            n_fail++; $display("FAIL user_noshift: got %h stb %0d want %h 1",
                               jif.user_upd_data, stb_count, jif.user_cap_data);
        end
        model_upd = jif.user_cap_data;
    endtask

    task automatic test_user_random();
        logic [31:0] tdo_v, tdi, cap, exp_t, exp_u;
        int n;
        for (int k = 0; k < 6; k++) begin
            n = (k == 0) ? 32 : int'($urandom_range(1, 32));
            tdi = $urandom;
            cap = $urandom;
            jif.user_cap_data = cap;
            dr_scan(n, tdi, tdo_v);
            exp_t = exp_dr_tdo(2, n, tdi, cap);
            exp_u = exp_user_final(n, tdi, cap);
            model_upd = exp_u;
            n_checks++;
            if (tdo_v !== exp_t || jif.user_upd_data !== exp_u || stb_count != 1 ||
                en_err != 0) begin
                n_fail++; $display("FAIL user_random n=%0d: tdo %h upd %h stb %0d want %h %h 1",
                                   n, tdo_v, jif.user_upd_data, stb_count, exp_t, exp_u);
            end
        end
    endtask

    task automatic test_unused_opcode();
        logic [3:0] t4, opc;
        logic [31:0] tdo_v, tdi, exp;
        for (int k = 0; k < 4; k++) begin
            opc = (k == 0) ? OPC_IDCODE : 4'($urandom);
            if (dr_kind(opc) == 2) opc = 4'b0110;
            ir_scan(opc, t4);
            model_ir = opc;
            jif.user_cap_data = $urandom;
            tdi = $urandom;
            dr_scan(12, tdi, tdo_v);
            exp = exp_dr_tdo(dr_kind(opc), 12, tdi, 32'h0);
            n_checks++;
            if (tdo_v !== exp || stb_count != 0 || jif.user_upd_data !== model_upd) begin
                n_fail++; $display("FAIL opcode_%h: tdo %h stb %0d upd %h want %h 0 %h",
                                   opc, tdo_v, stb_count, jif.user_upd_data, exp, model_upd);
            end
        end
    endtask

    task automatic test_tlr();
        logic [3:0] t4;
        ir_scan(OPC_USER, t4);
        tick(TLR, 1'b0);
        tick(RTI, 1'b0);
        #1;
        model_ir = RESET_OPC;
        n_checks++;
        if (jif.ir_out !== RESET_OPC) begin
            n_fail++; $display("FAIL tlr_ir_out: got %h want %h", jif.ir_out, RESET_OPC);
        end
    endtask

    task automatic test_trst_abort();
        logic [3:0] t4;
        logic [31:0] tdo_v;
        ir_scan(OPC_USER, t4);
        jif.user_cap_data = $urandom | 32'h1;
        dr_scan(0, 32'h0, tdo_v);
        stb_count = 0;
        tick(SELDR, 1'b0);
        tick(CAPDR, 1'b0);
        for (int i = 0; i < 5; i++) tick(SHDR, 1'b1);
        @(negedge tck);
        jif.tap_state = TLR;
        #2;
        trst = 1'b0;
        #1;
        n_checks++;
        if (jif.ir_out !== RESET_OPC || jif.user_sel !== 1'b0 ||
            jif.user_upd_data !== 32'h0 || jif.user_upd_stb !== 1'b0 ||
            jif.TDO !== 1'b0 || jif.TDO_EN !== 1'b0) begin
            n_fail++; $display("FAIL trst_abort: ir %h sel %b upd %h stb %b tdo %b en %b",
                               jif.ir_out, jif.user_sel, jif.user_upd_data,
                               jif.user_upd_stb, jif.TDO, jif.TDO_EN);
        end
        tick(TLR, 1'b0);
        @(negedge tck);
        trst = 1'b1;
        for (int i = 0; i < 3; i++) tick(RTI, 1'b0);
        n_checks++;
        if (stb_count != 0) begin
            n_fail++; $display("FAIL trst_no_stb: got %0d pulses want 0", stb_count);
        end
        model_ir = RESET_OPC;
        model_upd = '0;
    endtask

    initial begin
        test_reset();
        test_post_reset_dr();
        test_ir_scan();
        test_bypass();
        test_user_fixed();
        test_user_random();
        test_unused_opcode();
        test_tlr();
        test_trst_abort();
        test_post_reset_dr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
